bisr_repair_ctrl: RTL

Built-in self-repair controller wrapped around the 64-bank memory BIST engine.
- Sequences the BIST engine through its three address/data modes: LFSR, Gray and binary.
- Collects every failing 16-bit address ({bank[5:0], row[9:0]}) into a deduplicated repair table of spare entries.
- After the test, remaps functional accesses that hit a repaired address to a spare index for the memory controller datapath.

---
 rtl/bisr_pkg.sv | 48 ++++
 rtl/bisr_repair_cam.sv | 85 ++++++++
 rtl/bisr_repair_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bisr_pkg.sv
// bisr_pkg: shared definitions for the built-in self-repair controller.
//   - one-hot FSM state encoding (8 states)
//   - BIST mode constants driven onto BIST_MODE
//   - repair address geometry: 16 bits = {bank[5:0], row[9:0]}
//   - helpers mapping a state to the BIST enable / mode it drives
package bisr_pkg;

    localparam int ADDR_W = 16;
    localparam int BANK_W = 6;
    localparam int ROW_W  = 10;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
    } rep_addr_t;

    localparam logic [2:0] MODE_OFF  = 3'b000;
    localparam logic [2:0] MODE_LFSR = 3'b001;
    localparam logic [2:0] MODE_GRAY = 3'b010;
    localparam logic [2:0] MODE_BIN  = 3'b100;

    typedef enum logic [7:0] {
        S_IDLE       = 8'h01,
        S_RUN_LFSR   = 8'h02,
        S_DRAIN_LFSR = 8'h04,
        S_RUN_GRAY   = 8'h08,
        S_DRAIN_GRAY = 8'h10,
        S_RUN_BIN    = 8'h20,
        S_DRAIN_BIN  = 8'h40,
        S_DONE       = 8'h80
    } state_e;

    // Drain states keep the mode of their run state so the BIST mux is
    // stable while the last compare retires.
    function automatic logic [2:0] mode_of(state_e s);
        case (s)
            S_RUN_LFSR, S_DRAIN_LFSR: mode_of = MODE_LFSR;
            S_RUN_GRAY, S_DRAIN_GRAY: mode_of = MODE_GRAY;
            S_RUN_BIN,  S_DRAIN_BIN:  mode_of = MODE_BIN;
            default:                  mode_of = MODE_OFF;
        endcase
    endfunction

    function automatic logic is_run(state_e s);
        is_run = (s == S_RUN_LFSR) || (s == S_RUN_GRAY) || (s == S_RUN_BIN);
    endfunction

endpackage

// File: rtl/bisr_repair_cam.sv
// bisr_repair_cam: deduplicating repair table (CAM) of SPARE_NUM entries.
// Ports:
//   CLK, RSTN            clock, async active-low reset
//   clr_i                clear all entries, count and overflow
//   cap_vld_i/cap_addr_i capture port: failing address to insert
//   lkp_addr_i           lookup port address
//   lkp_hit_o/lkp_idx_o  lookup result (lowest matching index, 0 on miss)
//   cnt_o                number of valid entries
//   ovf_o                sticky: unique address seen while full
module bisr_repair_cam
    import bisr_pkg::*;
#(
    parameter int SPARE_NUM = 8,
    parameter int IDX_W     = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              clr_i,
    input  logic              cap_vld_i,
    input  logic [ADDR_W-1:0] cap_addr_i,
    input  logic [ADDR_W-1:0] lkp_addr_i,
    output logic              lkp_hit_o,
    output logic [IDX_W-1:0]  lkp_idx_o,
    output logic [IDX_W:0]    cnt_o,
    output logic              ovf_o
);

    logic [ADDR_W-1:0]    entry_q [SPARE_NUM];
    logic [SPARE_NUM-1:0] vld_q;
    logic [IDX_W:0]       cnt_q;
    logic                 ovf_q;
    logic [SPARE_NUM-1:0] cap_match, lkp_match;
    logic                 full, ins;

    always_comb begin
        cap_match = '0;
        lkp_match = '0;
        for (int i = 0; i < SPARE_NUM; i++) begin
            cap_match[i] = vld_q[i] && (entry_q[i] == cap_addr_i);
            lkp_match[i] = vld_q[i] && (entry_q[i] == lkp_addr_i);
        end
    end

    assign full = (cnt_q == (IDX_W+1)'(SPARE_NUM));
    assign ins  = cap_vld_i && !(|cap_match) && !full;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        lkp_idx_o = '0;
        for (int i = SPARE_NUM-1; i >= 0; i--) begin
            if (lkp_match[i]) lkp_idx_o = IDX_W'(i);
        end
    end
    assign lkp_hit_o = |lkp_match;

    // Address storage needs no reset; validity is tracked in vld_q.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < SPARE_NUM; i++) begin
            if (ins && (cnt_q == (IDX_W+1)'(i))) entry_q[i] <= cap_addr_i;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            vld_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (ins) begin
            for (int i = 0; i < SPARE_NUM; i++) begin
                if (cnt_q == (IDX_W+1)'(i)) vld_q[i] <= 1'b1;
            end
            cnt_q <= cnt_q + 1'b1;
        end else if (cap_vld_i && !(|cap_match)) begin
            ovf_q <= 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bisr_repair_ctrl.sv
// bisr_repair_ctrl: BISR controller around the 64-bank memory BIST engine.
// Steps BIST through LFSR, Gray and binary modes (each followed by a drain
// gap), captures failing addresses into a dedup repair table, and remaps
// functional accesses to spare indices once DONE.
// Ports:
//   CLK, RSTN                 clock, async active-low reset
//   START                     run request pulse (accepted in IDLE/DONE)
//   BIST_EN, BIST_MODE        registered controls to the BIST engine
//   BIST_PASS, NEED_REPAIR_ADDR  BIST mismatch flag and failing address
//   FUNC_ADDR                 functional access address
//   REMAP_HIT, REMAP_IDX      remap result (valid only in DONE)
//   BUSY, DONE                run status
//   REPAIR_OVF, REPAIR_CNT    table overflow (sticky) and entry count
//   FAIL_CNT                  saturating fail-event count, only when the
//                             BISR_FAIL_CNT_EN macro is defined
module bisr_repair_ctrl
    import bisr_pkg::*;
#(
    parameter int CYCLES_PER_MODE = 262144,
    parameter int DRAIN_CYCLES    = 4,
    parameter int SPARE_NUM       = 8,
    parameter int IDX_W           = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    output logic              BIST_EN,
    output logic [2:0]        BIST_MODE,
    input  logic              BIST_PASS,
    input  logic [ADDR_W-1:0] NEED_REPAIR_ADDR,
    input  logic [ADDR_W-1:0] FUNC_ADDR,
    output logic              REMAP_HIT,
    output logic [IDX_W-1:0]  REMAP_IDX,
    output logic              BUSY,
    output logic              DONE,
    output logic              REPAIR_OVF,
`ifdef BISR_FAIL_CNT_EN
    output logic [15:0]       FAIL_CNT,
`endif
    output logic [IDX_W:0]    REPAIR_CNT
);

    localparam int CNT_MAX = (CYCLES_PER_MODE > DRAIN_CYCLES) ? CYCLES_PER_MODE : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(CYCLES_PER_MODE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bist_en_q;
    logic [2:0]       bist_mode_q;
    logic             clr, cap_vld, lkp_hit;
    logic [IDX_W-1:0] lkp_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                cnt_d = '0;
                if (START) begin
                    state_d = S_RUN_LFSR;
                    clr     = 1'b1;
                end
            end
            S_RUN_LFSR:   if (cnt_q == RUN_LAST)   begin state_d = S_DRAIN_LFSR; cnt_d = '0; end
            S_DRAIN_LFSR: if (cnt_q == DRAIN_LAST) begin state_d = S_RUN_GRAY;   cnt_d = '0; end
            S_RUN_GRAY:   if (cnt_q == RUN_LAST)   begin state_d = S_DRAIN_GRAY; cnt_d = '0; end
            S_DRAIN_GRAY: if (cnt_q == DRAIN_LAST) begin state_d = S_RUN_BIN;    cnt_d = '0; end
            S_RUN_BIN:    if (cnt_q == RUN_LAST)   begin state_d = S_DRAIN_BIN;  cnt_d = '0; end
            S_DRAIN_BIN:  if (cnt_q == DRAIN_LAST) begin state_d = S_DONE;       cnt_d = '0; end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // BIST controls are registered from the next state so they flip on
    // the same edge as the state itself.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bist_en_q   <= 1'b0;
            bist_mode_q <= MODE_OFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bist_en_q   <= is_run(state_d);
            bist_mode_q <= mode_of(state_d);
        end
    end

    assign BIST_EN   = bist_en_q;
    assign BIST_MODE = bist_mode_q;
    assign DONE      = (state_q == S_DONE);
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cap_vld   = BIST_PASS && BUSY;

    bisr_repair_cam #(
        .SPARE_NUM (SPARE_NUM),
        .IDX_W     (IDX_W)
    ) u_cam (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .clr_i      (clr),
        .cap_vld_i  (cap_vld),
        .cap_addr_i (NEED_REPAIR_ADDR),
        .lkp_addr_i (FUNC_ADDR),
        .lkp_hit_o  (lkp_hit),
        .lkp_idx_o  (lkp_idx),
        .cnt_o      (REPAIR_CNT),
        .ovf_o      (REPAIR_OVF)
    );

    // The table is only trusted once the run has finished.
    assign REMAP_HIT = DONE && lkp_hit;
    assign REMAP_IDX = REMAP_HIT ? lkp_idx : '0;

`ifdef BISR_FAIL_CNT_EN
    logic [15:0] fail_cnt_q;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                                 fail_cnt_q <= '0;
        else if (clr)                              fail_cnt_q <= '0;
        else if (cap_vld && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
    end
    assign FAIL_CNT = fail_cnt_q;
`endif

endmodule
